clz_iter_unit: RTL
==================

# clz_iter_unit

Multi-cycle, parametrised leading-zero / leading-one counter for the CPU's execute stage, serving CLZ and CLO. Each cycle it scans STEP bits of the operand, starting at the MSB, and stops early at the first group that contains the target bit. A start/busy/done handshake lets the control FSM stall while a count is in progress. It supersedes the single-cycle priority-chain counter and decouples count latency from the critical path.

## Interface
- WIDTH, 32, operand width in bits; must be ≥ 2.
- STEP, 4, bits examined per scan cycle; must divide WIDTH exactly. STEP=1 gives a bit-serial unit; STEP=WIDTH gives a single scan cycle.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- mode  input  1  0 = count leading zeros (CLZ), 1 = count leading ones (CLO); sampled with start.
- data  input  WIDTH  operand; sampled with start.
- busy  output  1  high in every SCAN cycle.
- done  output  1  one-cycle pulse; count is valid from this cycle on.
- count  output  32  result, 0..WIDTH, zero-extended; holds until the next result is written.

## Operation
- States: IDLE, SCAN, DONE.
- Let N = WIDTH/STEP groups. Group 0 is data[WIDTH-1 -: STEP].
- IDLE or DONE with start=1:
  - Latch sh = mode ? ~data : data.
  - Clear acc and the group index gi.
  - Go to SCAN.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- SCAN, one group per cycle:
  - If the top STEP bits of sh are not all zero: p = leading zeros within that group (0..STEP-1); count ← acc + p; go to DONE.
  - Otherwise: acc ← acc + STEP; sh ← sh << STEP; gi ← gi + 1.
  - If the zero group was the last one (gi = N-1): count ← WIDTH; go to DONE.
- After inversion the unit always counts leading zeros, so CLO needs no separate datapath.
- start during SCAN is ignored. mode and data may change freely once start has been sampled.
- acc and count are wide enough to hold WIDTH without overflow.
- done is asserted exactly when the state is DONE. busy is asserted exactly when the state is SCAN.
- rst in any state, including mid-SCAN:
  - Next state is IDLE.
  - busy=0, done=0, count=0.
  - The in-flight operation is discarded.
  - rst has priority over a simultaneous start.

## Timing
- Reset values: state IDLE, busy 0, done 0, count 0, acc 0, gi 0, sh 0.
- Cycle numbering: start is sampled at edge E0. SCAN occupies cycle 1 onward.
- Let lz be the true count and g = min(floor(lz/STEP), N-1).
  - SCAN lasts g+1 cycles (cycles 1..g+1).
  - done is high in cycle g+2.
  - Worst case (lz ≥ WIDTH-STEP, including an all-zero operand): done in cycle N+1.
- count changes only on the edge entering DONE, or on rst.
- Back-to-back issue: start held high in the DONE cycle enters SCAN on the next edge. The issue interval is therefore g+2 cycles; there is no IDLE bubble.
- No combinational path from any input to any output.

## Test plan
1. WIDTH=32, STEP=4, CLZ, data=0x8000_0000 → busy high in cycle 1 only, done in cycle 2, count=0.
2. CLZ, data=0x0001_0000 → busy in cycles 1–4, done in cycle 5, count=15. Also data=0x0000_0001 → done in cycle 9, count=31.
3. CLZ, data=0x0000_0000 → busy for 8 cycles, done in cycle 9, count=32. CLO, data=0xFFFF_FFFF → identical timing, count=32.
4. CLO, data=0xFFFF_FFF0 → done in cycle 9, count=28. CLO, data=0x7FFF_FFFF → done in cycle 2, count=0.
5. Handshake:
   - Pulse start with 0xFFFF_FFFF while busy → ignored; the result of the first operation is unchanged.
   - Hold start=1 in the DONE cycle with data=0x00F0_0000 (CLZ) → SCAN entered next cycle; second done 4 cycles after the first; count=8.
6. Reset and alternate parameters:
   - Assert rst in cycle 3 of an all-zero scan → next cycle busy=0, done=0, count=0; no done pulse follows; a fresh start is accepted normally.
   - Repeat test 2 with STEP=1 → data=0x0000_0001 gives done in cycle 33, count=31.
   - Repeat test 2 with STEP=32 → every operand gives done in cycle 2.

Source files
------------

// File: rtl/clz_iter_unit.sv
// Iterative leading-zero / leading-one counter: scans STEP bits per cycle from the MSB
// and stops at the first group holding the target bit; start/busy/done handshake.
module clz_iter_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic [31:0]      count
);

    localparam int unsigned N  = WIDTH / STEP;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    r_acc;
    logic [GW-1:0]    r_gi;
    logic [31:0]      r_count;

    logic [STEP-1:0]  w_grp;
    logic             w_hit;
    logic             w_last;
    logic             w_load;
    logic [CW-1:0]    w_p;
    logic             w_found;

    assign w_grp  = r_sh[WIDTH-1 -: STEP];
    assign w_hit  = |w_grp;
    assign w_last = (r_gi == GW'(N - 1));
    assign w_load = (r_state != SCAN) && start;

    // Position of the first set bit inside the current group, counted from its MSB.
    always_comb begin
        w_p     = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (!w_found && w_grp[STEP-1-i]) begin
                w_p     = CW'(i);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SCAN;
            SCAN:    if (w_hit || w_last) w_next = DONE;
            DONE:    w_next = start ? SCAN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh    <= '0;
            r_acc   <= '0;
            r_gi    <= '0;
            r_count <= '0;
        end else if (w_load) begin
            // CLO is handled as CLZ of the inverted operand.
            r_sh  <= mode ? ~data : data;
            r_acc <= '0;
            r_gi  <= '0;
        end else if (r_state == SCAN) begin
            if (w_hit) begin
                r_count <= 32'(r_acc) + 32'(w_p);
            end else begin
                r_acc <= r_acc + CW'(STEP);
                r_sh  <= r_sh << STEP;
                r_gi  <= r_gi + 1'b1;
                if (w_last) r_count <= 32'(WIDTH);
            end
        end
    end

    assign busy  = (r_state == SCAN);
    assign done  = (r_state == DONE);
    assign count = r_count;

endmodule
